z80_run_monitor: RTL and testbench
==================================

# z80_run_monitor

Synthesizable run-control and trace monitor that sits beside the `z80` core on its bus. It passively observes `M1_L`/`MREQ_L`/`IORQ_L`/`RD_L`/`WR_L`/`addr_bus`/`data_bus`. It replaces the fixed "stop when PC > 0x0050" loop with a parametrised end address, N address watchpoints, a cycle-timeout, and an opcode-fetch trace FIFO, so both benches and FPGA builds get a stop reason and a fetch history.

## Interface
- `ADDR_W`, 16, address bus width
- `DATA_W`, 8, data bus width
- `END_ADDR`, 16'h0050, last legal opcode-fetch address
- `NUM_WATCH`, 4, number of watchpoint channels (1..8)
- `CNT_W`, 32, width of cycle/fetch counters and timeout limit
- `TRACE_DEPTH`, 16, trace FIFO entries (power of two, ≥2)
- `clk`  in  1  system clock, all state on posedge
- `rst_L`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a run (ignored in RUN)
- `M1_L`, `MREQ_L`, `IORQ_L`, `RD_L`, `WR_L`  in  1 each  core bus strobes, observed only
- `addr_bus`  in  ADDR_W  observed address
- `data_bus`  in  DATA_W  observed data (input-only tap)
- `watch_addr`  in  NUM_WATCH×ADDR_W  watchpoint addresses
- `watch_en`  in  NUM_WATCH  per-channel enable
- `watch_halt`  in  NUM_WATCH  per-channel "stop run on hit"
- `timeout_limit`  in  CNT_W  cycle limit; 0 disables timeout
- `running`, `done`  out  1 each  state indicators
- `stop_reason`  out  2  `stop_reason_t`
- `cycle_count`, `fetch_count`  out  CNT_W  saturating counters
- `watch_hit`  out  NUM_WATCH  sticky per-channel hit flags
- `trace_valid`  out  1  FIFO non-empty
- `trace_addr`  out  ADDR_W  oldest fetch address
- `trace_data`  out  DATA_W  oldest fetched opcode
- `trace_rd`  in  1  pop, honoured only when `trace_valid`
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  occupancy
- `trace_ovf`  out  1  sticky: an entry was overwritten

## Operation
- States: IDLE → RUN on `start`; RUN → DONE on a stop condition; DONE → RUN on `start`. Reset enters IDLE.
- On entry to RUN: clear counters, `watch_hit`, `stop_reason`, `trace_ovf`, and FIFO.
- Access capture:
  - Each cycle a strobe (`MREQ_L` or `IORQ_L`) is low, register addr, data, M1, RD, WR, and IORQ.
  - An access completes on the cycle the registered strobe was low and the current strobe is high.
  - The event uses the registered values.
- Fetch = completed MREQ access with M1 low and RD low.
  - Increments `fetch_count` and pushes {addr, data} to the trace.
- Watch hit: a completed MREQ or IORQ access, read or write, with `addr == watch_addr[i]` and `watch_en[i]`. Sets `watch_hit[i]`.
- Stop conditions, evaluated in RUN only:
  - PC_EXIT: fetch with `addr > END_ADDR` (unsigned).
  - WATCH: any hit channel with `watch_halt` set.
  - TIMEOUT: `cycle_count == timeout_limit` with a nonzero limit.
  - Simultaneous conditions: priority PC_EXIT > WATCH > TIMEOUT. All hit flags from that event are still set.
- The stopping fetch is itself traced and counted.
- Counters increment only in RUN and saturate at all-ones. `cycle_count` increments every RUN cycle.
- Trace is a ring of depth TRACE_DEPTH:
  - Push when full and no pop: overwrite oldest, set `trace_ovf`.
  - Push and pop in the same cycle when full: occupancy unchanged, no overflow.
  - Pop when empty: ignored.
- Pops are honoured in every state.

## Timing
- Reset values: `running`=0, `done`=0, `stop_reason`=STOP_NONE, counters 0, `watch_hit` 0, `trace_valid`=0, `trace_count`=0, `trace_ovf`=0, `trace_addr`/`trace_data` 0.
- `start` at edge n → `running`=1 after edge n.
- Event detection: the strobe rising at edge n produces the event at edge n+1, so counters, flags, and FIFO update one cycle after strobe release.
- Stop decision is registered in the same cycle as the event: `done`=1 and `stop_reason` valid at edge n+1.
- `trace_addr`/`trace_data` are show-ahead and valid combinationally whenever `trace_valid`=1. A pop at edge n presents the next entry after edge n.
- Reset asserted mid-run: all state clears immediately (async). No partial event is recorded after release.
- `start` coinciding with a pending stop event in DONE: the restart wins, and the event is discarded.

## Structure
- `z80_mon_pkg` holds:
  - `stop_reason_t` {STOP_NONE, STOP_PC_EXIT, STOP_WATCH, STOP_TIMEOUT} (2-bit)
  - `mon_state_t` {MON_IDLE, MON_RUN, MON_DONE}
  - the packed `bus_event_t` {addr, data, m1, rd, wr, iorq}
- Sub-module `z80_trace_fifo` implements the overwrite ring with pointers, count, and overflow. It is parametrised by depth and entry width.
- The top holds capture, watch compare (generate loop), counters, and the FSM.

## Test plan
- Fetch sequence at 0x0000..0x0051, END_ADDR=0x0050 → `done`=1, `stop_reason`=STOP_PC_EXIT one cycle after the 0x0051 fetch; `fetch_count`=0x52; last trace entry addr 0x0051.
- `watch_addr[2]`=0x8000, en and halt set; memory write to 0x8000 → `watch_hit`=4'b0100, STOP_WATCH. Repeat with halt clear → hit set, run continues.
- `timeout_limit`=100 with no fetches → STOP_TIMEOUT with `cycle_count`=100. Repeat with `timeout_limit`=0 → never stops on time.
- Same-event fetch at 0x0060 that also matches a halting watch → STOP_PC_EXIT, and `watch_hit` still set.
- Push 20 fetches into the depth-16 FIFO with no pops → `trace_count`=16, `trace_ovf`=1, oldest entry = 5th fetch. Then pop + push on the same cycle when full → count stays 16, and `trace_ovf` stays at its prior value.
- `rst_L` low mid-run for 1 ns between edges → all outputs at reset values immediately. Then `start` → a clean run with counters from 0.

Source files
------------

// File: rtl/z80_mon_pkg.sv
// Shared types for the Z80 run-control / trace monitor.
package z80_mon_pkg;

  // Bus widths the captured-event record is built for.
  localparam int MON_ADDR_W = 16;
  localparam int MON_DATA_W = 8;

  // Why the last run ended.
  typedef enum logic [1:0] {
    STOP_NONE    = 2'd0,
    STOP_PC_EXIT = 2'd1,
    STOP_WATCH   = 2'd2,
    STOP_TIMEOUT = 2'd3
  } stop_reason_t;

  // Run-control states.
  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2
  } mon_state_t;

  // One observed bus access; control fields are active-high here.
  typedef struct packed {
    logic [MON_ADDR_W-1:0] addr;
    logic [MON_DATA_W-1:0] data;
    logic                  m1;
    logic                  rd;
    logic                  wr;
    logic                  iorq;
  } bus_event_t;

  // Resolve simultaneous stop conditions: PC exit beats watch beats timeout.
  function automatic stop_reason_t pick_stop(input logic pc_exit,
                                             input logic watch_stop,
                                             input logic timeout_hit);
    if (pc_exit)          return STOP_PC_EXIT;
    else if (watch_stop)  return STOP_WATCH;
    else if (timeout_hit) return STOP_TIMEOUT;
    else                  return STOP_NONE;
  endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Overwriting ring buffer for opcode-fetch history. When full, a push
// without a pop discards the oldest entry and raises a sticky overflow flag.
// The head entry is presented show-ahead; outputs read as zero when empty.
module z80_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_L,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic full;
  logic empty;
  logic pop_ok;

  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign pop_ok = pop & ~empty;

  assign valid  = ~empty;
  assign dout   = empty ? '0 : mem[rd_ptr];
  assign count  = cnt_q;
  assign ovf    = ovf_q;

  // Entry storage: write the incoming fetch at the write pointer.
  // NOTE: the storage array has no reset; stale contents are never visible
  // because dout is gated by the occupancy count, which does reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer, occupancy and overflow bookkeeping.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (push && full) begin
        // Oldest entry leaves either by pop or by being overwritten.
        rd_ptr <= rd_ptr + PTR_ONE;
        if (!pop_ok) ovf_q <= 1'b1;
      end else if (push && pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else if (push) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        cnt_q  <= cnt_q - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/z80_run_monitor.sv
// Passive run-control and trace monitor for a Z80 bus. Observes the bus
// strobes, counts cycles and opcode fetches during a run, flags address
// watchpoints, stops on PC exit / halting watch / timeout, and keeps a
// history of recent opcode fetches.
module z80_run_monitor
  import z80_mon_pkg::*;
#(
  parameter int              ADDR_W      = MON_ADDR_W,
  parameter int              DATA_W      = MON_DATA_W,
  parameter logic [ADDR_W-1:0] END_ADDR  = 'h0050,
  parameter int              NUM_WATCH   = 4,
  parameter int              CNT_W       = 32,
  parameter int              TRACE_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_L,
  input  logic                          start,
  input  logic                          M1_L,
  input  logic                          MREQ_L,
  input  logic                          IORQ_L,
  input  logic                          RD_L,
  input  logic                          WR_L,
  input  logic [ADDR_W-1:0]             addr_bus,
  input  logic [DATA_W-1:0]             data_bus,
  input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
  input  logic [NUM_WATCH-1:0]          watch_en,
  input  logic [NUM_WATCH-1:0]          watch_halt,
  input  logic [CNT_W-1:0]              timeout_limit,
  output logic                          running,
  output logic                          done,
  output logic [1:0]                    stop_reason,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              fetch_count,
  output logic [NUM_WATCH-1:0]          watch_hit,
  output logic                          trace_valid,
  output logic [ADDR_W-1:0]             trace_addr,
  output logic [DATA_W-1:0]             trace_data,
  input  logic                          trace_rd,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_ovf
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------
  // Access capture
  // ---------------------------------------------------------------------
  logic       strobe;
  logic       strobe_q;
  bus_event_t bus_now;
  bus_event_t cap_q;
  bus_event_t ev_q;
  logic       ev_valid_q;

  assign strobe = ~MREQ_L | ~IORQ_L;

  // Present bus signals as an active-high event record.
  // NOTE: every field gets a default before the specific assignments so the
  // block stays purely combinational and no latch can be inferred.
  always_comb begin
    bus_now      = '0;
    bus_now.addr = addr_bus;
    bus_now.data = data_bus;
    bus_now.m1   = ~M1_L;
    bus_now.rd   = ~RD_L;
    bus_now.wr   = ~WR_L;
    bus_now.iorq = ~IORQ_L;
  end

  // Track the strobe, hold the latest in-strobe bus values, and emit one
  // event on the cycle after the strobe is released.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      strobe_q   <= 1'b0;
      cap_q      <= '0;
      ev_q       <= '0;
      ev_valid_q <= 1'b0;
    end else begin
      strobe_q   <= strobe;
      if (strobe) cap_q <= bus_now;
      ev_valid_q <= strobe_q & ~strobe;
      if (strobe_q && !strobe) ev_q <= cap_q;
    end
  end

  // ---------------------------------------------------------------------
  // Event classification and watch compare
  // ---------------------------------------------------------------------
  logic                 fetch_now;
  logic                 pc_exit;
  logic [NUM_WATCH-1:0] hit_now;
  logic                 watch_stop;

  assign fetch_now = ev_valid_q & ~ev_q.iorq & ev_q.m1 & ev_q.rd;
  assign pc_exit   = fetch_now & (ev_q.addr > END_ADDR);

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
    assign hit_now[g] = ev_valid_q & (ev_q.rd | ev_q.wr) & watch_en[g] &
                        (ev_q.addr == watch_addr[g*ADDR_W +: ADDR_W]);
  end

  assign watch_stop = |(hit_now & watch_halt);

  // ---------------------------------------------------------------------
  // Run control, counters and sticky flags
  // ---------------------------------------------------------------------
  mon_state_t           state_q;
  stop_reason_t         reason_q;
  logic [CNT_W-1:0]     cycle_q;
  logic [CNT_W-1:0]     fetch_q;
  logic [NUM_WATCH-1:0] hit_q;
  logic [CNT_W-1:0]     cycle_next;
  logic [CNT_W-1:0]     fetch_next;
  logic                 timeout_hit;
  logic                 stop_now;

  assign cycle_next  = (cycle_q == '1) ? cycle_q : cycle_q + CNT_ONE;
  assign fetch_next  = (fetch_q == '1) ? fetch_q : fetch_q + CNT_ONE;
  // The timeout fires on the cycle that brings the count up to the limit.
  assign timeout_hit = (timeout_limit != '0) && (cycle_next == timeout_limit);
  assign stop_now    = pc_exit | watch_stop | timeout_hit;

  // Run FSM with registered status outputs and run-scoped counters.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= MON_IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      reason_q <= STOP_NONE;
      cycle_q  <= '0;
      fetch_q  <= '0;
      hit_q    <= '0;
    end else begin
      case (state_q)
        MON_IDLE, MON_DONE: begin
          // A restart discards any event completing on the same edge.
          if (start) begin
            state_q  <= MON_RUN;
            running  <= 1'b1;
            done     <= 1'b0;
            reason_q <= STOP_NONE;
            cycle_q  <= '0;
            fetch_q  <= '0;
            hit_q    <= '0;
          end
        end
        MON_RUN: begin
          cycle_q <= cycle_next;
          if (fetch_now) fetch_q <= fetch_next;
          hit_q <= hit_q | hit_now;
          if (stop_now) begin
            state_q  <= MON_DONE;
            running  <= 1'b0;
            done     <= 1'b1;
            reason_q <= pick_stop(pc_exit, watch_stop, timeout_hit);
          end
        end
        default: begin
          state_q <= MON_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign stop_reason = reason_q;
  assign cycle_count = cycle_q;
  assign fetch_count = fetch_q;
  assign watch_hit   = hit_q;

  // ---------------------------------------------------------------------
  // Fetch trace
  // ---------------------------------------------------------------------
  logic               trace_clear;
  logic               trace_push;
  logic [ENTRY_W-1:0] trace_dout;

  assign trace_clear = start & (state_q != MON_RUN);
  assign trace_push  = fetch_now & (state_q == MON_RUN);

  z80_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace (
    .clk   (clk),
    .rst_L (rst_L),
    .clear (trace_clear),
    .push  (trace_push),
    .din   ({ev_q.addr, ev_q.data}),
    .pop   (trace_rd),
    .valid (trace_valid),
    .dout  (trace_dout),
    .count (trace_count),
    .ovf   (trace_ovf)
  );

  assign trace_addr = trace_dout[ENTRY_W-1 -: ADDR_W];
  assign trace_data = trace_dout[DATA_W-1:0];

endmodule

// File: tb/tb_z80_run_monitor.sv
// Self-checking bench for z80_run_monitor: directed scenarios plus random
// bus traffic, compared every cycle against a transaction-level model.
module tb_z80_run_monitor;
  import z80_mon_pkg::*;

  localparam int NW    = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] END_A = 16'h0050;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        start;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus;
  logic [15:0] waddr [NW];
  logic [NW*16-1:0] watch_addr;
  logic [NW-1:0]    watch_en, watch_halt;
  logic [31:0] timeout_limit;
  logic        running, done;
  logic [1:0]  stop_reason;
  logic [31:0] cycle_count, fetch_count;
  logic [NW-1:0] watch_hit;
  logic        trace_valid;
  logic [15:0] trace_addr;
  logic [7:0]  trace_data;
  logic        trace_rd;
  logic [4:0]  trace_count;
  logic        trace_ovf;

  assign watch_addr = {waddr[3], waddr[2], waddr[1], waddr[0]};

  z80_run_monitor #(
    .ADDR_W(16), .DATA_W(8), .END_ADDR(END_A), .NUM_WATCH(NW),
    .CNT_W(32), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_L(rst_L), .start(start),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .addr_bus(addr_bus), .data_bus(data_bus),
    .watch_addr(watch_addr), .watch_en(watch_en), .watch_halt(watch_halt),
    .timeout_limit(timeout_limit),
    .running(running), .done(done), .stop_reason(stop_reason),
    .cycle_count(cycle_count), .fetch_count(fetch_count), .watch_hit(watch_hit),
    .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_rd(trace_rd), .trace_count(trace_count), .trace_ovf(trace_ovf)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          at;     // clock edge on which the access takes effect
    logic [15:0] addr;
    logic [7:0]  data;
    bit          m1, rd, wr, io;
  } sched_t;

  sched_t      sched[$];
  logic [23:0] m_trace[$];
  bit          m_running, m_done, m_ovf;
  logic [1:0]  m_reason;
  logic [31:0] m_cycle, m_fetch;
  logic [NW-1:0] m_hit;

  int edge_cnt   = 0;
  int start_edge = -1;
  int pop_edge   = -1;
  bit rand_pop   = 0;

  task automatic model_reset();
    m_running = 0; m_done = 0; m_ovf = 0;
    m_reason = 2'(STOP_NONE);
    m_cycle = '0; m_fetch = '0; m_hit = '0;
    m_trace.delete();
    sched.delete();
  endtask

  task automatic model_edge(input bit st, input bit pop);
    sched_t s;
    bit have, fetch, wstop, pc, tmo;
    have = 0; wstop = 0;
    if (sched.size() > 0 && sched[0].at == edge_cnt) begin
      s = sched.pop_front();
      have = 1;
    end
    if (st && !m_running) begin
      m_running = 1; m_done = 0; m_ovf = 0;
      m_reason = 2'(STOP_NONE);
      m_cycle = '0; m_fetch = '0; m_hit = '0;
      m_trace.delete();
      return;
    end
    if (pop && m_trace.size() > 0) void'(m_trace.pop_front());
    if (!m_running) return;
    if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
    fetch = have && !s.io && s.m1 && s.rd;
    if (have)
      for (int i = 0; i < NW; i++)
        if (watch_en[i] && (s.rd || s.wr) && s.addr == waddr[i]) begin
          m_hit[i] = 1'b1;
          if (watch_halt[i]) wstop = 1;
        end
    if (fetch) begin
      if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      m_trace.push_back({s.addr, s.data});
      if (m_trace.size() > DEPTH) begin
        void'(m_trace.pop_front());
        m_ovf = 1;
      end
    end
    pc  = fetch && (s.addr > END_A);
    tmo = (timeout_limit != 0) && (m_cycle == timeout_limit);
    if (pc || wstop || tmo) begin
      m_running = 0; m_done = 1;
      if (pc)         m_reason = 2'(STOP_PC_EXIT);
      else if (wstop) m_reason = 2'(STOP_WATCH);
      else            m_reason = 2'(STOP_TIMEOUT);
    end
  endtask

  task automatic compare_all();
    logic [15:0] ea;
    logic [7:0]  ed;
    ea = (m_trace.size() > 0) ? m_trace[0][23:8] : 16'h0;
    ed = (m_trace.size() > 0) ? m_trace[0][7:0]  : 8'h0;
    check("running",     64'(running),     64'(m_running));
    check("done",        64'(done),        64'(m_done));
    check("stop_reason", 64'(stop_reason), 64'(m_reason));
    check("cycle_count", 64'(cycle_count), 64'(m_cycle));
    check("fetch_count", 64'(fetch_count), 64'(m_fetch));
    check("watch_hit",   64'(watch_hit),   64'(m_hit));
    check("trace_valid", 64'(trace_valid), 64'(m_trace.size() > 0));
    check("trace_count", 64'(trace_count), 64'(m_trace.size()));
    check("trace_ovf",   64'(trace_ovf),   64'(m_ovf));
    check("trace_addr",  64'(trace_addr),  64'(ea));
    check("trace_data",  64'(trace_data),  64'(ed));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_running"},     64'(running),     64'd0);
    check({pfx, "_done"},        64'(done),        64'd0);
    check({pfx, "_stop_reason"}, 64'(stop_reason), 64'(STOP_NONE));
    check({pfx, "_cycle"},       64'(cycle_count), 64'd0);
    check({pfx, "_fetch"},       64'(fetch_count), 64'd0);
    check({pfx, "_hit"},         64'(watch_hit),   64'd0);
    check({pfx, "_tvalid"},      64'(trace_valid), 64'd0);
    check({pfx, "_tcount"},      64'(trace_count), 64'd0);
    check({pfx, "_tovf"},        64'(trace_ovf),   64'd0);
    check({pfx, "_taddr"},       64'(trace_addr),  64'd0);
    check({pfx, "_tdata"},       64'(trace_data),  64'd0);
  endtask

  // ---------------- stimulus ----------------
  task automatic bus_idle();
    M1_L = 1; MREQ_L = 1; IORQ_L = 1; RD_L = 1; WR_L = 1;
  endtask

  // One clock: drive start/pop, take the edge, update model, compare.
  task automatic step();
    bit st, pop;
    st  = (edge_cnt + 1 == start_edge);
    pop = (edge_cnt + 1 == pop_edge) || (rand_pop && $urandom_range(0, 3) == 0);
    start = st; trace_rd = pop;
    @(posedge clk);
    edge_cnt++;
    model_edge(st, pop);
    @(negedge clk);
    compare_all();
    start = 0; trace_rd = 0;
  endtask

  // kind: 0 fetch, 1 mem read, 2 mem write, 3 io read, 4 io write.
  // Returns the edge on which the access takes effect (next step call).
  task automatic access(input logic [15:0] a, input logic [7:0] d,
                        input int kind, input int low_cyc, output int at);
    sched_t s;
    s.addr = a; s.data = d;
    s.m1 = (kind == 0);
    s.rd = (kind == 0 || kind == 1 || kind == 3);
    s.wr = (kind == 2 || kind == 4);
    s.io = (kind >= 3);
    for (int j = 0; j < low_cyc; j++) begin
      addr_bus = a; data_bus = d;
      M1_L = ~s.m1; RD_L = ~s.rd; WR_L = ~s.wr;
      MREQ_L = s.io; IORQ_L = ~s.io;
      step();
    end
    s.at = edge_cnt + 2;
    sched.push_back(s);
    bus_idle();
    step();
    at = s.at;
  endtask

  task automatic acc(input logic [15:0] a, input int kind);
    int at;
    access(a, 8'($urandom_range(0, 255)), kind, $urandom_range(1, 3), at);
  endtask

  task automatic do_start();
    start_edge = edge_cnt + 1;
    step();
  endtask

  task automatic pulse_reset();
    #2 rst_L = 0;
    #1 check_reset_vals("midrst");
    rst_L = 1;
    model_reset();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int at;
    rst_L = 0; start = 0; trace_rd = 0;
    bus_idle(); addr_bus = '0; data_bus = '0;
    for (int i = 0; i < NW; i++) waddr[i] = '0;
    watch_en = '0; watch_halt = '0; timeout_limit = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_L = 1;

    // PC exit after sequential fetches 0x0000..0x0051.
    do_start();
    for (int a = 0; a <= 'h51; a++) acc(16'(a), 0);
    step();
    check("pc_done",   64'(done),        64'd1);
    check("pc_reason", 64'(stop_reason), 64'(STOP_PC_EXIT));
    check("pc_fetch",  64'(fetch_count), 64'h52);
    for (int i = 0; i < DEPTH - 1; i++) begin pop_edge = edge_cnt + 1; step(); end
    check("pc_last_addr", 64'(trace_addr), 64'h51);

    // Halting watch on a memory write.
    waddr[2] = 16'h8000; watch_en = 4'b0100; watch_halt = 4'b0100;
    do_start();
    acc(16'h0010, 0);
    acc(16'h8000, 2);
    step();
    check("wh_hit",    64'(watch_hit),   64'b0100);
    check("wh_reason", 64'(stop_reason), 64'(STOP_WATCH));
    // Same watch without halt: run continues.
    watch_halt = '0;
    do_start();
    acc(16'h8000, 2);
    repeat (3) step();
    check("wn_hit",     64'(watch_hit), 64'b0100);
    check("wn_running", 64'(running),   64'd1);
    acc(16'h0051, 0); step();
    watch_en = '0;

    // Timeout at 100 cycles with no fetches, then disabled timeout.
    timeout_limit = 100;
    do_start();
    repeat (105) step();
    check("to_reason", 64'(stop_reason), 64'(STOP_TIMEOUT));
    check("to_cycle",  64'(cycle_count), 64'd100);
    timeout_limit = 0;
    do_start();
    repeat (300) step();
    check("to0_running", 64'(running),     64'd1);
    check("to0_cycle",   64'(cycle_count), 64'd300);
    acc(16'h0051, 0); step();

    // Fetch past the end that also hits a halting watch.
    waddr[1] = 16'h0060; watch_en = 4'b0010; watch_halt = 4'b0010;
    do_start();
    acc(16'h0060, 0); step();
    check("both_reason", 64'(stop_reason), 64'(STOP_PC_EXIT));
    check("both_hit",    64'(watch_hit),   64'b0010);
    watch_en = '0; watch_halt = '0;

    // Trace overflow: 20 fetches into 16 entries.
    do_start();
    for (int i = 0; i < 20; i++) acc(16'(16'h10 + i), 0);
    step();
    check("ovf_count",  64'(trace_count), 64'd16);
    check("ovf_flag",   64'(trace_ovf),   64'd1);
    check("ovf_oldest", 64'(trace_addr),  64'h14);
    access(16'h0030, 8'h5A, 0, 1, at); pop_edge = at; step();
    check("pp_count",  64'(trace_count), 64'd16);
    check("pp_ovf",    64'(trace_ovf),   64'd1);
    check("pp_oldest", 64'(trace_addr),  64'h15);
    acc(16'h0051, 0); step();
    // Push+pop when exactly full leaves overflow clear.
    do_start();
    for (int i = 0; i < 16; i++) acc(16'(16'h20 + i), 0);
    step();
    check("full_ovf", 64'(trace_ovf), 64'd0);
    access(16'h0031, 8'hA5, 0, 2, at); pop_edge = at; step();
    check("pp0_count", 64'(trace_count), 64'd16);
    check("pp0_ovf",   64'(trace_ovf),   64'd0);
    acc(16'h0032, 0); step();
    check("pp1_ovf", 64'(trace_ovf), 64'd1);
    acc(16'h0051, 0); step();

    // Asynchronous reset mid-run, then a clean run.
    do_start();
    for (int i = 0; i < 5; i++) acc(16'(i), 0);
    step();
    pulse_reset();
    repeat (2) step();
    do_start();
    for (int i = 0; i < 3; i++) acc(16'(i), 0);
    step();
    check("rerun_fetch", 64'(fetch_count), 64'd3);
    acc(16'h0051, 0); step();

    // Random traffic with random watch/timeout config and random pops.
    rand_pop = 1;
    for (int run = 0; run < 10; run++) begin
      for (int i = 0; i < NW; i++)
        waddr[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 'h4F))
                                               : 16'(16'h8000 + $urandom_range(0, 3));
      watch_en      = 4'($urandom_range(0, 15));
      watch_halt    = 4'($urandom_range(0, 15));
      timeout_limit = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(30, 300));
      if (!m_running) do_start();
      for (int k = 0; k < 60 && m_running; k++) begin
        int r;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        if (r < 80)      a = 16'($urandom_range(0, 'h4F));
        else if (r < 92) a = waddr[$urandom_range(0, NW - 1)];
        else if (r < 96) a = 16'(16'h8000 + $urandom_range(0, 3));
        else             a = 16'($urandom_range('h51, 'hFFFF));
        acc(a, $urandom_range(0, 4));
        if ($urandom_range(0, 4) == 0) step();
      end
      step();
      if (m_done) begin
        acc(16'h0005, 0);
        step();
        // Restart on the same edge that a fetch completes.
        access(16'($urandom_range(0, 'hFF)), 8'h77, 0, 1, at);
        start_edge = at;
        step();
      end
    end
    rand_pop = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
